// File: rtl/prbs_xnor_checker.sv
// Self-synchronising checker for an XNOR-feedback PRBS serial stream: lock detection plus saturating error count.
// Optional build macro PRBS_CHK_BITCNT_EN adds a saturating 32-bit count of LOCKED beats (bit_count).
module prbs_xnor_checker #(
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned TAP_B       = 6,
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_d;
  logic               err_pulse_d;
  logic [ERR_W-1:0]   err_count_d;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]        bit_count_d;
`endif

  logic exp_bit;
  logic bit_match;
  logic lockup;

  // Predicted next bit from history; all-ones is the XNOR lockup pattern that predicts itself.
  assign exp_bit   = ~(hist_q[WIDTH-1] ^ hist_q[TAP_B-1]);
  assign bit_match = (in_bit == exp_bit);
  assign lockup    = &hist_q;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SEED;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
`ifdef PRBS_CHK_BITCNT_EN
      bit_count <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
`ifdef PRBS_CHK_BITCNT_EN
      bit_count <= bit_count_d;
`endif
    end
  end

  // Next-state and next-output logic; only valid beats advance the checker.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    locked_d    = locked;
    err_pulse_d = 1'b0;
    err_count_d = clear ? '0 : err_count;
`ifdef PRBS_CHK_BITCNT_EN
    bit_count_d = clear ? '0 : bit_count;
`endif

    if (in_valid) begin
      case (state_q)
        ST_SEED: begin
          hist_d = {hist_q[WIDTH-2:0], in_bit};
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            state_d = ST_SEARCH;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end

        ST_SEARCH: begin
          hist_d = {hist_q[WIDTH-2:0], in_bit};
          if (bit_match && !lockup) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end

        ST_LOCKED: begin
          // Flywheel on the prediction so a corrupted bit never poisons later predictions.
          hist_d = {hist_q[WIDTH-2:0], exp_bit};
`ifdef PRBS_CHK_BITCNT_EN
          if (!clear && (bit_count != '1)) begin
            bit_count_d = bit_count + 32'd1;
          end
`endif
          if (bit_match) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (clear) begin
              err_count_d = ERR_W'(1);
            end else if (err_count != '1) begin
              err_count_d = err_count + ERR_W'(1);
            end
            if (miss_q == MISS_W'(UNLOCK_ERRS - 1)) begin
              state_d  = ST_SEED;
              hist_d   = '0;
              fill_d   = '0;
              match_d  = '0;
              miss_d   = '0;
              locked_d = 1'b0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end

        default: begin
          state_d  = ST_SEED;
          hist_d   = '0;
          fill_d   = '0;
          match_d  = '0;
          miss_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Scoreboard bench for prbs_xnor_checker: two instances (ERR_W=16 and ERR_W=4) share one directed stimulus stream.
module tb_prbs_xnor_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear = 1'b0;
  logic        locked_a, err_pulse_a, locked_b, err_pulse_b;
  logic [15:0] err_count_a;
  logic [3:0]  err_count_b;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_count_a, bit_count_b;
`endif

  always #5 clk = ~clk;

  prbs_xnor_checker #(.ERR_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_count(bit_count_a)
`endif
  );

  prbs_xnor_checker #(.ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_count(bit_count_b)
`endif
  );

  typedef struct {
    logic lk;
    logic p;
    int   ea;
    int   eb;
    int   bc;
    int   tag;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [6:0] g;
  int         bc_exp = 0;
  logic       prev_lk = 1'b0;

  task automatic check(input string name, input int tag, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s tag=%0d actual=%0d required=%0d", name, tag, act, req);
    end
  endtask

  // Reference XNOR generator (taps 7,6) producing the transmitted stream.
  function automatic logic gen_next();
    logic o;
    o = ~(g[6] ^ g[5]);
    g = {g[5:0], o};
    return o;
  endfunction

  // One clock of stimulus; the expected post-edge outputs are queued at the edge.
  task automatic step(input logic v, input logic b, input logic clr,
                      input logic lk, input logic p, input int ea, input int tag);
    exp_t e;
    in_valid = v;
    in_bit   = b;
    clear    = clr;
    if (v && prev_lk) bc_exp++;
    if (clr) bc_exp = 0;
    @(posedge clk);
    e.lk  = lk;
    e.p   = p;
    e.ea  = ea;
    e.eb  = (ea > 15) ? 15 : ea;
    e.bc  = bc_exp;
    e.tag = tag;
    sb_q.push_back(e);
    prev_lk = lk;
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic beat(input logic flip, input logic clr, input logic lk, input logic p,
                      input int ea, input int tag);
    logic b;
    b = gen_next() ^ flip;
    step(1'b1, b, clr, lk, p, ea, tag);
  endtask

  task automatic check_reset_state(input int tag);
    check("rst_locked_a", tag, 64'(locked_a), 0);
    check("rst_pulse_a", tag, 64'(err_pulse_a), 0);
    check("rst_count_a", tag, 64'(err_count_a), 0);
    check("rst_locked_b", tag, 64'(locked_b), 0);
    check("rst_pulse_b", tag, 64'(err_pulse_b), 0);
    check("rst_count_b", tag, 64'(err_count_b), 0);
`ifdef PRBS_CHK_BITCNT_EN
    check("rst_bitcnt_a", tag, 64'(bit_count_a), 0);
`endif
  endtask

  // Monitor: outputs are presented every cycle; compare half a clock after the edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("locked_a", mon_e.tag, 64'(locked_a), 64'(mon_e.lk));
      check("pulse_a", mon_e.tag, 64'(err_pulse_a), 64'(mon_e.p));
      check("count_a", mon_e.tag, 64'(err_count_a), 64'(mon_e.ea));
      check("locked_b", mon_e.tag, 64'(locked_b), 64'(mon_e.lk));
      check("pulse_b", mon_e.tag, 64'(err_pulse_b), 64'(mon_e.p));
      check("count_b", mon_e.tag, 64'(err_count_b), 64'(mon_e.eb));
`ifdef PRBS_CHK_BITCNT_EN
      check("bitcnt_a", mon_e.tag, 64'(bit_count_a), 64'(mon_e.bc));
      check("bitcnt_b", mon_e.tag, 64'(bit_count_b), 64'(mon_e.bc));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    g = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0);
    rst_n = 1'b1;

    // Clean stream: 7 seed beats + 8 matches, then 254 more clean beats.
    for (int k = 1; k <= 269; k++) begin
      beat(1'b0, 1'b0, (k >= 15), 1'b0, 0, 1000 + k);
      if (k == 20) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1500);
    end

    // Single flipped bit while locked.
    for (int k = 1; k <= 100; k++)
      beat((k == 100), 1'b0, 1'b1, (k == 100), (k == 100) ? 1 : 0, 2000 + k);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2101);
    for (int k = 1; k <= 10; k++) beat(1'b0, 1'b0, 1'b1, 1'b0, 1, 2200 + k);

    // Clear, four consecutive errors drop lock, clean stream relocks after 15 beats.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 3000);
    for (int i = 1; i <= 4; i++) beat(1'b1, 1'b0, (i < 4), 1'b1, i, 3000 + i);
    for (int k = 1; k <= 30; k++) beat(1'b0, 1'b0, (k >= 15), 1'b0, 4, 3100 + k);

    // Twenty isolated errors: ERR_W=4 instance saturates at 15; then clear with same-beat error.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4000);
    for (int i = 1; i <= 20; i++) begin
      beat(1'b1, 1'b0, 1'b1, 1'b1, i, 4000 + 2 * i - 1);
      beat(1'b0, 1'b0, 1'b1, 1'b0, i, 4000 + 2 * i);
    end
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1, 4100);
    beat(1'b0, 1'b0, 1'b1, 1'b0, 1, 4101);

    // Asynchronous reset while locked.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state(5000);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(5001);
    rst_n   = 1'b1;
    prev_lk = 1'b0;
    bc_exp  = 0;

    // Constant ones: seeds the lockup pattern, must never lock.
    for (int k = 1; k <= 50; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 6000 + k);

    for (int w = 0; w < 4 && sb_q.size() > 0; w++) @(posedge clk);
    #1;
    check("scoreboard_drain", 7000, 64'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
